// File: rtl/mac_seq_pkg.sv
// Shared types and widths for the MAC sequencer: FSM state encoding and
// the command-length-to-element-count conversion.
package mac_seq_pkg;

  localparam int LEN_W  = 8;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 9;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FEED   = 3'd1,
    DRAIN1 = 3'd2,
    DRAIN2 = 3'd3,
    RESULT = 3'd4
  } state_t;

  // A length of zero encodes the full 256-element vector.
  function automatic logic [CNT_W-1:0] len_to_cnt(input logic [LEN_W-1:0] len);
    if (len == '0) return CNT_W'(256);
    return {1'b0, len};
  endfunction

endpackage

// File: rtl/mac_seq.sv
// Sequencer for an external MAC unit: accepts a vector length, streams operand
// pairs into the unit with the control strobes it needs, and presents its result.
module mac_seq
  import mac_seq_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [LEN_W-1:0]         cmd_len,
  input  logic                     op_valid,
  output logic                     op_ready,
  input  logic signed [DATA_W-1:0] op_a,
  input  logic signed [DATA_W-1:0] op_b,
  output logic signed [DATA_W-1:0] a_value,
  output logic signed [DATA_W-1:0] b_value,
  output logic                     aen,
  output logic                     ben,
  output logic                     men,
  output logic                     sen,
  output logic                     start,
  output logic                     sreset,
  input  logic signed [DATA_W-1:0] s_out,
  input  logic                     sat,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic signed [DATA_W-1:0] res_data,
  output logic                     res_sat
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_remaining;
  logic             r_start;
  logic             r_vld_p1;
  logic             r_last_p1;
  logic             r_vld_p2;
  logic             r_last_p2;
  logic             w_cmd_fire;
  logic             w_op_fire;
  logic             w_last;

  // cmd_ready is held low while reset is asserted so no command is taken mid-reset.
  assign cmd_ready  = (r_state == IDLE) && rst_n;
  assign op_ready   = (r_state == FEED);
  assign res_valid  = (r_state == RESULT);
  assign w_cmd_fire = cmd_valid && cmd_ready;
  assign w_op_fire  = op_valid && op_ready;
  assign w_last     = (r_remaining == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_cmd_fire) w_next = FEED;
      FEED:    if (w_op_fire && w_last) w_next = DRAIN1;
      DRAIN1:  w_next = DRAIN2;
      DRAIN2:  w_next = RESULT;
      RESULT:  if (res_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_remaining <= '0;
    else if (w_cmd_fire) r_remaining <= len_to_cnt(cmd_len);
    else if (w_op_fire)  r_remaining <= r_remaining - CNT_W'(1);
  end

  // p1: multiply slot of each accepted pair; p2: its accumulate/close slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start   <= 1'b0;
      r_vld_p1  <= 1'b0;
      r_last_p1 <= 1'b0;
      r_vld_p2  <= 1'b0;
      r_last_p2 <= 1'b0;
    end else begin
      r_start   <= w_cmd_fire;
      r_vld_p1  <= w_op_fire;
      r_last_p1 <= w_op_fire && w_last;
      r_vld_p2  <= r_vld_p1;
      r_last_p2 <= r_last_p1;
    end
  end

  assign a_value  = op_a;
  assign b_value  = op_b;
  assign aen      = w_op_fire;
  assign ben      = w_op_fire;
  assign start    = r_start;
  assign men      = r_vld_p1;
  assign sen      = r_vld_p2 && !r_last_p2;
  assign sreset   = r_vld_p2 && r_last_p2;
  assign res_data = s_out;
  assign res_sat  = sat;

endmodule
